// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW interlock, decode-stage forwarding selects and branch flush sequencing
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int PIPE_DEPTH  = 3,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_SLOTS = 2,
  parameter int FWD_EN      = 1,
  parameter int SEL_W       = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_rs1_used,
  input  logic                  dec_rs2_used,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_wen,
  input  logic                  dec_is_load,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush_fetch,
  output logic                  flush_dec,
  output logic                  issue,
  output logic [SEL_W-1:0]      fwd_sel_rs1,
  output logic [SEL_W-1:0]      fwd_sel_rs2,
  output logic [15:0]           stall_count
);
  localparam int CNT_W = $clog2(FLUSH_SLOTS + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [PIPE_DEPTH-1:0] t_valid, t_load;
  logic [REG_ADDR_W-1:0] t_rd [PIPE_DEPTH];
  logic [1:0]            haz;
  logic [SEL_W-1:0]      sel [2];
  logic                  run, kill;
  // Entries are only valid for rd!=0, so a match can never involve x0.
  always_comb begin
    haz = '0;
    sel[0] = '0;
    sel[1] = '0;
    for (int j = 0; j < 2; j++)
      for (int k = PIPE_DEPTH - 1; k >= 0; k--)
        if ((j == 0 ? dec_rs1_used : dec_rs2_used) && t_valid[k] && t_rd[k] == (j == 0 ? dec_rs1 : dec_rs2)) begin
          haz[j] = FWD_EN == 0 || (t_load[k] && k < LOAD_LAT);
          sel[j] = haz[j] ? '0 : SEL_W'(k + 1);
        end
  end
  assign run         = state == RUN;
  assign stall       = !rst && dec_valid && |haz && run && !branch_taken;
  assign issue       = !rst && dec_valid && !stall && run && !branch_taken;
  assign flush_fetch = !rst && (!run || branch_taken);
  assign flush_dec   = flush_fetch;
  assign kill        = rst || stall || !run || !dec_valid;
  assign fwd_sel_rs1 = kill ? '0 : sel[0];
  assign fwd_sel_rs2 = kill ? '0 : sel[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      t_valid     <= '0;
      t_load      <= '0;
      stall_count <= '0;
    end else begin
      t_valid     <= (t_valid << 1) | PIPE_DEPTH'(issue && dec_wen && dec_rd != '0);
      t_load      <= (t_load << 1) | PIPE_DEPTH'(issue && dec_is_load);
      stall_count <= stall_count + 16'(stall && stall_count != 16'hFFFF);
      if (run) begin
        if (branch_taken && FLUSH_SLOTS > 1) begin
          state <= FLUSH;
          cnt   <= CNT_W'(FLUSH_SLOTS - 1);
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state <= RUN;
      end
    end
    for (int k = PIPE_DEPTH - 1; k > 0; k--) t_rd[k] <= t_rd[k-1];
    t_rd[0] <= dec_rd;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of a forwarding instance and an interlock-only, 4-slot-flush instance
module tb_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic dec_valid, dec_rs1_used, dec_rs2_used, dec_wen, dec_is_load, branch_taken;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic stall_f, flush_fetch_f, flush_dec_f, issue_f;
  logic stall_i, flush_fetch_i, flush_dec_i, issue_i;
  logic [1:0] fwd_sel_rs1_f, fwd_sel_rs2_f, fwd_sel_rs1_i, fwd_sel_rs2_i;
  logic [15:0] stall_count_f, stall_count_i;
  int checks = 0, errors = 0;
  logic [6:0] exp;

  always #5 clk = ~clk;

  hazard_ctrl #(.FWD_EN(1), .FLUSH_SLOTS(2)) u_fwd (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd), .dec_wen(dec_wen),
    .dec_is_load(dec_is_load), .branch_taken(branch_taken), .stall(stall_f), .flush_fetch(flush_fetch_f),
    .flush_dec(flush_dec_f), .issue(issue_f), .fwd_sel_rs1(fwd_sel_rs1_f), .fwd_sel_rs2(fwd_sel_rs2_f),
    .stall_count(stall_count_f));

  hazard_ctrl #(.FWD_EN(0), .FLUSH_SLOTS(4)) u_ilk (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd), .dec_wen(dec_wen),
    .dec_is_load(dec_is_load), .branch_taken(branch_taken), .stall(stall_i), .flush_fetch(flush_fetch_i),
    .flush_dec(flush_dec_i), .issue(issue_i), .fwd_sel_rs1(fwd_sel_rs1_i), .fwd_sel_rs2(fwd_sel_rs2_i),
    .stall_count(stall_count_i));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd, input logic wen, input logic ld);
    dec_valid = v; dec_rs1 = r1; dec_rs1_used = u1; dec_rs2 = r2; dec_rs2_used = u2;
    dec_rd = rd; dec_wen = wen; dec_is_load = ld;
  endtask

  task automatic randomize_inputs;
    set_dec(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom));
    branch_taken = 1'($urandom);
  endtask

  task automatic apply_reset;
    step;
    rst = 1;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    branch_taken = 0;
    step;
    rst = 0;
  endtask

  task automatic test_reset;
    step;
    rst = 1;
    randomize_inputs();
    for (int c = 0; c < 2; c++) begin
      step;
      randomize_inputs();
      #1;
      checks++;
      if ({stall_f, flush_fetch_f, flush_dec_f, issue_f, fwd_sel_rs1_f, fwd_sel_rs2_f, stall_count_f} !== 24'h0) begin
        errors++;
        $display("FAIL reset_fwd cycle %0d: got %h want 0", c,
                 {stall_f, flush_fetch_f, flush_dec_f, issue_f, fwd_sel_rs1_f, fwd_sel_rs2_f, stall_count_f});
      end
      checks++;
      if ({stall_i, flush_fetch_i, flush_dec_i, issue_i, fwd_sel_rs1_i, fwd_sel_rs2_i, stall_count_i} !== 24'h0) begin
        errors++;
        $display("FAIL reset_ilk cycle %0d: got %h want 0", c,
                 {stall_i, flush_fetch_i, flush_dec_i, issue_i, fwd_sel_rs1_i, fwd_sel_rs2_i, stall_count_i});
      end
    end
    step;
    rst = 0;
    branch_taken = 0;
    set_dec(1, 5, 1, 6, 1, 0, 0, 0);
    #1;
    checks++;
    if ({stall_i, issue_i, stall_f, issue_f, fwd_sel_rs1_f, fwd_sel_rs2_f} !== 8'b0101_0000) begin
      errors++;
      $display("FAIL reset_tags_empty: got %b want 01010000",
               {stall_i, issue_i, stall_f, issue_f, fwd_sel_rs1_f, fwd_sel_rs2_f});
    end
  endtask

  task automatic test_forwarding;
    apply_reset;
    set_dec(1, 0, 0, 0, 0, 5, 1, 0);
    #1;
    checks++;
    if (issue_f !== 1'b1) begin errors++; $display("FAIL fwd_issue_add: got %b want 1", issue_f); end
    step;
    set_dec(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    checks++;
    if ({stall_f, issue_f, fwd_sel_rs1_f} !== 4'b0101) begin
      errors++; $display("FAIL fwd_ex_rs1: got %b want 0101", {stall_f, issue_f, fwd_sel_rs1_f});
    end
    step;
    set_dec(1, 1, 1, 2, 1, 10, 1, 0);
    #1;
    checks++;
    if ({issue_f, fwd_sel_rs1_f, fwd_sel_rs2_f} !== 5'b10000) begin
      errors++; $display("FAIL fwd_independent: got %b want 10000", {issue_f, fwd_sel_rs1_f, fwd_sel_rs2_f});
    end
    step;
    set_dec(1, 6, 1, 5, 1, 0, 0, 0);
    #1;
    checks++;
    if ({stall_f, fwd_sel_rs1_f, fwd_sel_rs2_f} !== 5'b0_10_11) begin
      errors++; $display("FAIL fwd_mem_wb: got %b want 01011", {stall_f, fwd_sel_rs1_f, fwd_sel_rs2_f});
    end
    step;
    set_dec(0, 10, 1, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({issue_f, fwd_sel_rs1_f} !== 3'b000) begin
      errors++; $display("FAIL fwd_invalid_dec: got %b want 000", {issue_f, fwd_sel_rs1_f});
    end
  endtask

  task automatic test_load_use;
    apply_reset;
    set_dec(1, 0, 0, 0, 0, 7, 1, 1);
    #1;
    step;
    set_dec(1, 0, 0, 7, 1, 8, 1, 0);
    #1;
    checks++;
    if ({stall_f, issue_f, fwd_sel_rs2_f} !== 4'b1000) begin
      errors++; $display("FAIL load_use_stall: got %b want 1000", {stall_f, issue_f, fwd_sel_rs2_f});
    end
    step;
    #1;
    checks++;
    if ({stall_f, issue_f, fwd_sel_rs2_f, stall_count_f} !== {4'b0110, 16'd1}) begin
      errors++; $display("FAIL load_use_release: got %h want 60001", {stall_f, issue_f, fwd_sel_rs2_f, stall_count_f});
    end
  endtask

  task automatic test_interlock;
    apply_reset;
    set_dec(1, 0, 0, 0, 0, 9, 1, 0);
    #1;
    checks++;
    if (issue_i !== 1'b1) begin errors++; $display("FAIL ilk_issue_add: got %b want 1", issue_i); end
    step;
    set_dec(1, 9, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({stall_i, issue_i, fwd_sel_rs1_i} !== 4'b1000) begin
        errors++; $display("FAIL ilk_stall cycle %0d: got %b want 1000", c, {stall_i, issue_i, fwd_sel_rs1_i});
      end
      step;
    end
    #1;
    checks++;
    if ({stall_i, issue_i, fwd_sel_rs1_i, stall_count_i} !== {4'b0100, 16'd3}) begin
      errors++; $display("FAIL ilk_release: got %h want 40003", {stall_i, issue_i, fwd_sel_rs1_i, stall_count_i});
    end
  endtask

  task automatic test_flush;
    apply_reset;
    set_dec(1, 11, 1, 0, 0, 11, 1, 0);
    branch_taken = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp[2:0] = {c < 2, c < 2, c >= 2};
      checks++;
      if ({flush_fetch_f, flush_dec_f, issue_f} !== exp[2:0]) begin
        errors++; $display("FAIL flush2 cycle %0d: got %b want %b", c, {flush_fetch_f, flush_dec_f, issue_f}, exp[2:0]);
      end
      exp[2:0] = {c < 4, c < 4, c >= 4};
      checks++;
      if ({flush_fetch_i, flush_dec_i, issue_i} !== exp[2:0]) begin
        errors++; $display("FAIL flush4 cycle %0d: got %b want %b", c, {flush_fetch_i, flush_dec_i, issue_i}, exp[2:0]);
      end
      if (c == 2) begin
        checks++;
        if ({stall_f, fwd_sel_rs1_f} !== 3'b000) begin
          errors++; $display("FAIL flush_bubbles: got %b want 000", {stall_f, fwd_sel_rs1_f});
        end
      end
      step;
      branch_taken = 0;
    end
  endtask

  task automatic test_back_to_back;
    apply_reset;
    set_dec(1, 0, 0, 0, 0, 7, 1, 1);
    #1;
    step;
    set_dec(1, 0, 0, 7, 1, 8, 1, 0);
    branch_taken = 1;
    #1;
    checks++;
    if ({stall_f, flush_fetch_f, flush_dec_f, issue_f} !== 4'b0110) begin
      errors++; $display("FAIL branch_vs_hazard: got %b want 0110", {stall_f, flush_fetch_f, flush_dec_f, issue_f});
    end
    step;
    branch_taken = 0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (stall_count_f !== 16'd0) begin errors++; $display("FAIL branch_no_stall_count: got %0d want 0", stall_count_f); end
    apply_reset;
    set_dec(1, 0, 0, 0, 0, 0, 1, 0);
    #1;
    step;
    set_dec(1, 0, 1, 0, 1, 3, 1, 0);
    #1;
    checks++;
    if ({stall_f, issue_f, fwd_sel_rs1_f, fwd_sel_rs2_f, stall_i, issue_i} !== 8'b0100_0001) begin
      errors++; $display("FAIL x0_dependency: got %b want 01000001",
                         {stall_f, issue_f, fwd_sel_rs1_f, fwd_sel_rs2_f, stall_i, issue_i});
    end
    apply_reset;
    set_dec(1, 0, 0, 0, 0, 0, 0, 0);
    branch_taken = 1;
    #1;
    step;
    branch_taken = 0;
    #1;
    checks++;
    if (flush_fetch_i !== 1'b1) begin errors++; $display("FAIL mid_flush_active: got %b want 1", flush_fetch_i); end
    step;
    rst = 1;
    #1;
    checks++;
    if ({flush_fetch_i, flush_dec_i, flush_fetch_f} !== 3'b000) begin
      errors++; $display("FAIL rst_in_flush: got %b want 000", {flush_fetch_i, flush_dec_i, flush_fetch_f});
    end
    step;
    rst = 0;
    #1;
    checks++;
    if ({flush_fetch_i, flush_dec_i, issue_i} !== 3'b001) begin
      errors++; $display("FAIL flush_aborted: got %b want 001", {flush_fetch_i, flush_dec_i, issue_i});
    end
  endtask

  initial begin
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    branch_taken = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_interlock();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline interlock and forwarding controller for the in-order RISC-V core. It tracks destination tags of instructions issued past decode in a PIPE_DEPTH-entry tag pipeline. It raises stall on unresolved RAW hazards and generates decode-stage forwarding selects. A small FSM squashes FLUSH_SLOTS younger instructions after a taken branch. It sits beside the control unit and drives the fetch/decode pipeline registers' hold and nop inputs.

Parameters:
REG_ADDR_W, 5, register index width
PIPE_DEPTH, 3, post-decode stages tracked (entry 0 = EX, 1 = MEM, PIPE_DEPTH-1 = WB)
LOAD_LAT, 1, first entry index at which load data is forwardable
FLUSH_SLOTS, 2, younger instructions killed per taken branch (>=1)
FWD_EN, 1, 1 = forwarding enabled, 0 = interlock only
SEL_W, $clog2(PIPE_DEPTH+1), forwarding select width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_valid  in  1  decode holds a valid instruction
dec_rs1  in  REG_ADDR_W  source 1 index
dec_rs2  in  REG_ADDR_W  source 2 index
dec_rs1_used  in  1  instruction reads rs1
dec_rs2_used  in  1  instruction reads rs2
dec_rd  in  REG_ADDR_W  destination index
dec_wen  in  1  instruction writes rd
dec_is_load  in  1  instruction is a load
branch_taken  in  1  taken branch/jump resolved in EX this cycle
stall  out  1  hold fetch, PC and decode; insert bubble into EX
flush_fetch  out  1  nop fetch pipeline register output
flush_dec  out  1  nop decode pipeline register output
issue  out  1  decode instruction enters EX this cycle
fwd_sel_rs1  out  SEL_W  0 = regfile, k+1 = result of entry k
fwd_sel_rs2  out  SEL_W  as above for rs2
stall_count  out  16  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock clk. rst is synchronous and active-high.
- Reset: all tag entries invalid, FSM = RUN, flush counter 0, stall_count 0. All outputs are 0 in the cycle after reset, independent of inputs. Reset mid-flush or mid-stall aborts it at that edge.
- Tag entry: {valid, rd, is_load}. An entry is valid only if the issued instruction has dec_wen=1 and rd!=0.
- Shift every cycle: entry[k] <= entry[k-1].
  - entry[0] <= decode tag if issue, else bubble (valid=0).
  - WB (entry[PIPE_DEPTH-1]) writes the regfile at the end of its cycle. The value is visible to decode from the next cycle only.
- Hazard per source s (used, index!=0): find the youngest valid entry k with rd==s.
  - No match: fwd_sel=0.
  - FWD_EN=0: any match -> hazard.
  - FWD_EN=1: match with is_load and k<LOAD_LAT -> hazard; otherwise fwd_sel=k+1.
- stall = dec_valid & (hazard_rs1 | hazard_rs2) & FSM==RUN & !branch_taken.
- fwd_sel is forced to 0 when stall, FSM==FLUSH or dec_valid=0.
- issue = dec_valid & !stall & FSM==RUN & !branch_taken.
- FSM RUN:
  - branch_taken -> flush_fetch=flush_dec=1 and no issue.
  - If FLUSH_SLOTS>1: counter <= FLUSH_SLOTS-1, go to FLUSH; else stay in RUN.
- FSM FLUSH:
  - flush_fetch=flush_dec=1, issue=0, decrement counter.
  - Return to RUN when counter reaches 1 (i.e. exactly FLUSH_SLOTS flush cycles in total).
  - branch_taken is ignored (EX holds bubbles).
- Simultaneous branch_taken and hazard: flush wins, stall=0.
- stall_count increments when stall=1 and saturates at 0xFFFF.
- Dependencies on x0 never stall or forward.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> stall=0, flush_*=0, issue=0, fwd_sel=0, stall_count=0; tag entries empty.
2. FWD_EN=1: issue add x5, next cycle decode rs1=x5 -> stall=0, fwd_sel_rs1=1. Insert one independent instr, then rs2=x5 -> fwd_sel_rs2=3.
3. Load-use, LOAD_LAT=1: lw x7, next cycle add rs2=x7 -> stall=1 for exactly 1 cycle, then fwd_sel_rs2=2, issue=1, stall_count=1.
4. FWD_EN=0, PIPE_DEPTH=3: add x9, next cycle rs1=x9 -> stall=1 for 3 cycles, fwd_sel=0, issue on 4th cycle, stall_count=3.
5. FLUSH_SLOTS=2: branch_taken=1 with dec_valid=1 -> flush_fetch=flush_dec=1 for 2 cycles, issue=0, two bubbles enter entry[0], FSM back to RUN.
6. branch_taken in same cycle as load-use hazard -> stall=0, flush=1. rs1=x0 with pending entry rd=0 -> no stall, fwd_sel=0. Assert rst during FLUSH -> flushes drop next cycle.
